// File: rtl/multi_pipeline_controller.sv
// Byte-stream command decoder driving per-pipeline write/commit/swap/reset strobes.
// Optional trailing XOR checksum byte per command when CTRL_CHECKSUM_EN is defined.
module multi_pipeline_controller #(
  parameter int unsigned N_PIPELINES    = 2,
  parameter int unsigned N_BLOCKS       = 32,
  parameter int unsigned DATA_WIDTH     = 16,
  parameter int unsigned INSTR_WIDTH    = 32,
  parameter int unsigned REG_ADDR_WIDTH = 4,
  parameter int unsigned TIMEOUT_CYCLES = 65535,
  localparam int unsigned BW = $clog2(N_BLOCKS),
  localparam int unsigned PW = $clog2(N_PIPELINES),
  localparam int unsigned RW = BW + REG_ADDR_WIDTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [7:0]               in_byte_i,
  input  logic                     in_ready_i,
  output logic                     next_o,
  output logic [BW-1:0]            block_target_o,
  output logic [RW-1:0]            reg_target_o,
  output logic [DATA_WIDTH-1:0]    data_out_o,
  output logic [INSTR_WIDTH-1:0]   instr_out_o,
  output logic [2*DATA_WIDTH-1:0]  delay_out_o,
  output logic [N_PIPELINES-1:0]   instr_write_o,
  output logic [N_PIPELINES-1:0]   reg_write_o,
  output logic [N_PIPELINES-1:0]   reg_commit_o,
  output logic [N_PIPELINES-1:0]   alloc_delay_o,
  output logic [N_PIPELINES-1:0]   pipeline_reset_o,
  output logic [N_PIPELINES-1:0]   full_reset_o,
  input  logic [N_PIPELINES-1:0]   regfile_syncing_i,
  input  logic [N_PIPELINES-1:0]   resetting_i,
  input  logic                     swapping_i,
  output logic [N_PIPELINES-1:0]   enables_o,
  output logic [PW-1:0]            active_pipe_o,
  output logic                     swap_o,
  output logic                     set_input_gain_o,
  output logic                     set_output_gain_o,
  output logic                     invalid_o,
  output logic                     timeout_o,
  output logic [7:0]               status_o,
  output logic [7:0]               state_o
);

  localparam int unsigned DB = DATA_WIDTH / 8;
  localparam int unsigned IB = INSTR_WIDTH / 8;
  localparam int unsigned LB = 2 * DATA_WIDTH / 8;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [3:0] OpWrInstr = 4'd1;
  localparam logic [3:0] OpWrReg   = 4'd2;
  localparam logic [3:0] OpCommit  = 4'd3;
  localparam logic [3:0] OpAlloc   = 4'd4;
  localparam logic [3:0] OpSwap    = 4'd5;
  localparam logic [3:0] OpRstPipe = 4'd6;
  localparam logic [3:0] OpInGain  = 4'd7;
  localparam logic [3:0] OpOutGain = 4'd8;

`ifdef CTRL_CHECKSUM_EN
  typedef enum logic [3:0] {
    StReady = 4'd0, StDecode = 4'd1, StGetBlock = 4'd2, StGetReg = 4'd3, StGetData = 4'd4,
    StGetInstr = 4'd5, StGetDelay = 4'd6, StGetCheck = 4'd7, StExec = 4'd8, StRegWait = 4'd9,
    StSwapWait = 4'd10, StResetWait = 4'd11
  } state_e;
`else
  typedef enum logic [3:0] {
    StReady = 4'd0, StDecode = 4'd1, StGetBlock = 4'd2, StGetReg = 4'd3, StGetData = 4'd4,
    StGetInstr = 4'd5, StGetDelay = 4'd6, StExec = 4'd8, StRegWait = 4'd9,
    StSwapWait = 4'd10, StResetWait = 4'd11
  } state_e;
`endif

  state_e                    state_q, state_d;
  logic [7:0]                cmd_q;
  logic [BW-1:0]             block_q;
  logic [REG_ADDR_WIDTH-1:0] reg_q;
  logic [DATA_WIDTH-1:0]     data_q;
  logic [INSTR_WIDTH-1:0]    instr_q;
  logic [2*DATA_WIDTH-1:0]   delay_q;
  logic [7:0]                cnt_q, cnt_d;
  logic [TW-1:0]             tmo_q;
  logic                      skip_q;
  logic [N_PIPELINES-1:0]    enables_q, enables_d;
  logic [PW-1:0]             active_q, active_d;
  logic [7:0]                status_q, status_d;
`ifdef CTRL_CHECKSUM_EN
  logic [7:0]                csum_q;
`endif

  logic [3:0]             op, pidx;
  logic [N_PIPELINES-1:0] p_oh, old_oh;
  logic                   in_get, accept, tmo_hit;

  assign op     = cmd_q[7:4];
  assign pidx   = cmd_q[3:0];
  assign p_oh   = N_PIPELINES'(1) << pidx;
  assign old_oh = N_PIPELINES'(1) << active_q;

  // Where a command goes once all its payload bytes are in.
  function automatic state_e after_fields(input logic [3:0] opc);
`ifdef CTRL_CHECKSUM_EN
    return (opc == OpWrReg) ? StGetCheck : StGetCheck;
`else
    return (opc == OpWrReg) ? StRegWait : StExec;
`endif
  endfunction

  always_comb begin
    in_get = 1'b0;
    case (state_q)
      StGetBlock, StGetReg, StGetData, StGetInstr, StGetDelay: in_get = 1'b1;
`ifdef CTRL_CHECKSUM_EN
      StGetCheck: in_get = 1'b1;
`endif
      default: in_get = 1'b0;
    endcase
  end

  // skip_q blanks in_ready for the cycle following a consumed byte.
  assign accept  = in_ready_i && !skip_q && !reset && (state_q == StReady || in_get);
  assign tmo_hit = in_get && !accept && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
  assign next_o  = accept;

  always_comb begin
    state_d           = state_q;
    cnt_d             = cnt_q;
    enables_d         = enables_q;
    active_d          = active_q;
    status_d          = status_q;
    instr_write_o     = '0;
    reg_write_o       = '0;
    reg_commit_o      = '0;
    alloc_delay_o     = '0;
    pipeline_reset_o  = '0;
    full_reset_o      = '0;
    swap_o            = 1'b0;
    set_input_gain_o  = 1'b0;
    set_output_gain_o = 1'b0;
    invalid_o         = 1'b0;
    timeout_o         = 1'b0;
    if (tmo_hit) begin
      timeout_o = 1'b1;
      status_d  = {pidx, 4'h3};
      state_d   = StReady;
    end else begin
      case (state_q)
        StReady: if (accept) state_d = StDecode;
        StDecode: begin
          if (op == 4'd0 || op > OpOutGain) begin
            invalid_o = 1'b1;
            status_d  = 8'h02;
            state_d   = StReady;
          end else if ((op != OpInGain && op != OpOutGain && 32'(pidx) >= N_PIPELINES) ||
                       (op == OpSwap && pidx == 4'(active_q))) begin
            invalid_o = 1'b1;
            status_d  = {pidx, 4'h2};
            state_d   = StReady;
          end else if (op == OpWrInstr || op == OpWrReg) begin
            state_d = StGetBlock;
          end else if (op == OpAlloc || op == OpInGain || op == OpOutGain) begin
            state_d = StGetData;
            cnt_d   = 8'(DB - 1);
          end else begin
            state_d = after_fields(op);
          end
        end
        StGetBlock: if (accept) begin
          if (op == OpWrInstr) begin
            state_d = StGetInstr;
            cnt_d   = 8'(IB - 1);
          end else begin
            state_d = StGetReg;
          end
        end
        StGetReg: if (accept) begin
          state_d = StGetData;
          cnt_d   = 8'(DB - 1);
        end
        StGetData: if (accept) begin
          if (cnt_q != 8'd0) begin
            cnt_d = cnt_q - 8'd1;
          end else if (op == OpAlloc) begin
            state_d = StGetDelay;
            cnt_d   = 8'(LB - 1);
          end else begin
            state_d = after_fields(op);
          end
        end
        StGetInstr, StGetDelay: if (accept) begin
          if (cnt_q != 8'd0) cnt_d = cnt_q - 8'd1;
          else state_d = after_fields(op);
        end
`ifdef CTRL_CHECKSUM_EN
        StGetCheck: if (accept) begin
          if (in_byte_i == csum_q) begin
            state_d = (op == OpWrReg) ? StRegWait : StExec;
          end else begin
            invalid_o = 1'b1;
            status_d  = {pidx, 4'h4};
            state_d   = StReady;
          end
        end
`endif
        StExec: begin
          status_d = {pidx, 4'h1};
          state_d  = StReady;
          case (op)
            OpWrInstr: instr_write_o     = p_oh;
            OpCommit:  reg_commit_o      = p_oh;
            OpAlloc:   alloc_delay_o     = p_oh;
            OpRstPipe: pipeline_reset_o  = p_oh;
            OpInGain:  set_input_gain_o  = 1'b1;
            OpOutGain: set_output_gain_o = 1'b1;
            OpSwap: begin
              enables_d    = enables_q | p_oh;
              swap_o       = 1'b1;
              reg_commit_o = p_oh;
              status_d     = status_q;
              state_d      = StSwapWait;
            end
            default: ;
          endcase
        end
        StRegWait: if (!swapping_i && !(|(regfile_syncing_i & p_oh))) begin
          reg_write_o = p_oh;
          status_d    = {pidx, 4'h1};
          state_d     = StReady;
        end
        StSwapWait: if (!swapping_i) begin
          active_d     = PW'(pidx);
          enables_d    = enables_q & ~old_oh;
          full_reset_o = old_oh;
          state_d      = StResetWait;
        end
        StResetWait: if (resetting_i == '0) begin
          status_d = {pidx, 4'h1};
          state_d  = StReady;
        end
        default: state_d = StReady;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StReady;
      cmd_q     <= '0;
      block_q   <= '0;
      reg_q     <= '0;
      data_q    <= '0;
      instr_q   <= '0;
      delay_q   <= '0;
      cnt_q     <= '0;
      tmo_q     <= '0;
      skip_q    <= 1'b0;
      enables_q <= N_PIPELINES'(1);
      active_q  <= '0;
      status_q  <= '0;
`ifdef CTRL_CHECKSUM_EN
      csum_q    <= '0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      skip_q    <= accept;
      enables_q <= enables_d;
      active_q  <= active_d;
      status_q  <= status_d;
      tmo_q     <= (in_get && !accept) ? tmo_q + TW'(1) : '0;
      if (accept) begin
        case (state_q)
          StReady:    cmd_q   <= in_byte_i;
          StGetBlock: block_q <= in_byte_i[BW-1:0];
          StGetReg:   reg_q   <= in_byte_i[REG_ADDR_WIDTH-1:0];
          StGetData:  data_q  <= DATA_WIDTH'({data_q, in_byte_i});
          StGetInstr: instr_q <= INSTR_WIDTH'({instr_q, in_byte_i});
          StGetDelay: delay_q <= (2*DATA_WIDTH)'({delay_q, in_byte_i});
          default: ;
        endcase
`ifdef CTRL_CHECKSUM_EN
        csum_q <= (state_q == StReady) ? in_byte_i : (csum_q ^ in_byte_i);
`endif
      end
    end
  end

  assign block_target_o = block_q;
  assign reg_target_o   = {block_q, reg_q};
  assign data_out_o     = data_q;
  assign instr_out_o    = instr_q;
  assign delay_out_o    = delay_q;
  assign enables_o      = enables_q;
  assign active_pipe_o  = active_q;
  assign status_o       = status_q;
  assign state_o        = 8'(state_q);

endmodule

// File: tb/tb_multi_pipeline_controller.sv
// Scoreboard bench for multi_pipeline_controller: expected strobe events are queued as
// commands are sent and matched against strobes observed on the falling clock edge.
module tb_multi_pipeline_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  in_byte;
  logic        in_ready;
  logic        next;
  logic [4:0]  block_target;
  logic [8:0]  reg_target;
  logic [15:0] data_out;
  logic [31:0] instr_out;
  logic [31:0] delay_out;
  logic [1:0]  instr_write, reg_write, reg_commit, alloc_delay, pipeline_reset, full_reset;
  logic [1:0]  regfile_syncing;
  logic [1:0]  resetting = 2'b00;
  logic        swapping = 1'b0;
  logic [1:0]  enables;
  logic        active_pipe;
  logic        swap, set_input_gain, set_output_gain, invalid, timeout;
  logic [7:0]  status, state;

  multi_pipeline_controller #(
    .N_PIPELINES(2), .N_BLOCKS(32), .DATA_WIDTH(16), .INSTR_WIDTH(32),
    .REG_ADDR_WIDTH(4), .TIMEOUT_CYCLES(20)
  ) dut (
    .clk(clk), .reset(reset), .in_byte_i(in_byte), .in_ready_i(in_ready), .next_o(next),
    .block_target_o(block_target), .reg_target_o(reg_target), .data_out_o(data_out),
    .instr_out_o(instr_out), .delay_out_o(delay_out), .instr_write_o(instr_write),
    .reg_write_o(reg_write), .reg_commit_o(reg_commit), .alloc_delay_o(alloc_delay),
    .pipeline_reset_o(pipeline_reset), .full_reset_o(full_reset),
    .regfile_syncing_i(regfile_syncing), .resetting_i(resetting), .swapping_i(swapping),
    .enables_o(enables), .active_pipe_o(active_pipe), .swap_o(swap),
    .set_input_gain_o(set_input_gain), .set_output_gain_o(set_output_gain),
    .invalid_o(invalid), .timeout_o(timeout), .status_o(status), .state_o(state)
  );

  always #5 clk = ~clk;

  localparam logic [7:0] KIw = 8'd1, KRw = 8'd2, KRc = 8'd3, KAd = 8'd4, KPr = 8'd5;
  localparam logic [7:0] KFr = 8'd6, KSw = 8'd7, KIg = 8'd8, KOg = 8'd9, KInv = 8'd10;
  localparam logic [7:0] KTmo = 8'd11;

  int          total = 0;
  int          bad = 0;
  logic [31:0] sbq[$];
  logic [7:0]  cmdq[$];
  int          swap_evts = 0, fr_evts = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input logic [7:0] k, input logic [23:0] v);
    sbq.push_back({k, v});
  endtask

  task automatic obs(input logic [7:0] k, input logic [23:0] v);
    if (v != 24'd0) begin
      if (sbq.size() == 0) check("unexpected_evt", {k, v}, 32'h0);
      else check("evt", {k, v}, sbq.pop_front());
    end
  endtask

  always @(negedge clk) begin
    obs(KIw, 24'(instr_write));
    obs(KRw, 24'(reg_write));
    obs(KRc, 24'(reg_commit));
    obs(KAd, 24'(alloc_delay));
    obs(KPr, 24'(pipeline_reset));
    obs(KFr, 24'(full_reset));
    obs(KSw, 24'(swap));
    obs(KIg, 24'(set_input_gain));
    obs(KOg, 24'(set_output_gain));
    obs(KInv, 24'(invalid));
    obs(KTmo, 24'(timeout));
    if (swap) swap_evts++;
    if (|full_reset) fr_evts++;
  end

  // Pipeline model: swapping high 4 cycles after a swap, resetting high 2 after full_reset.
  int swap_seen = 0, fr_seen = 0, swap_left = 0, rst_left = 0;
  always @(posedge clk) begin
    #1;
    if (swap_evts != swap_seen) begin
      swap_seen = swap_evts; swapping = 1'b1; swap_left = 4;
    end else if (swap_left > 0) begin
      swap_left--;
      if (swap_left == 0) swapping = 1'b0;
    end
    if (fr_evts != fr_seen) begin
      fr_seen = fr_evts; resetting = 2'b01; rst_left = 2;
    end else if (rst_left > 0) begin
      rst_left--;
      if (rst_left == 0) resetting = 2'b00;
    end
  end

  // Called at a falling edge; returns at a falling edge after the byte was consumed.
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_byte = b;
    in_ready = 1'b1;
    while (n < 60) begin
      #1;
      if (next) break;
      @(negedge clk);
      n++;
    end
    if (n >= 60) begin
      check("next_timeout", 32'(next), 32'h1);
      in_ready = 1'b0;
    end else begin
      @(negedge clk);
      #1;
      check("next_after_accept", 32'(next), 32'h0);
      in_ready = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic send_cmd();
    logic [7:0] x = 8'h00;
    foreach (cmdq[i]) begin
      x = x ^ cmdq[i];
      send_byte(cmdq[i]);
    end
`ifdef CTRL_CHECKSUM_EN
    send_byte(x);
`endif
  endtask

  task automatic wait_ready();
    int n = 0;
    while (state != 8'h00 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("ready_timeout", 32'(state), 32'h0);
  endtask

  initial begin
    in_byte = 8'h00; in_ready = 1'b0; regfile_syncing = 2'b00; reset = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_state", 32'(state), 32'h0);
    check("rst_enables", 32'(enables), 32'h1);
    check("rst_active", 32'(active_pipe), 32'h0);
    check("rst_status", 32'(status), 32'h0);
    check("rst_fields", {reg_target, data_out[7:0], 15'(block_target)}, 32'h0);
    check("rst_strobes", {instr_write, reg_write, reg_commit, alloc_delay, pipeline_reset,
                          full_reset, swap, invalid, timeout, next}, 32'h0);
    reset = 1'b0;
    @(negedge clk);

    // WRITE_REG pipe 1, block 5, reg 3, data 0x1234
    push(KRw, 24'h2);
    cmdq = '{8'h21, 8'h05, 8'h03, 8'h12, 8'h34};
    send_cmd();
    wait_ready();
    check("wr_block", 32'(block_target), 32'h5);
    check("wr_regtgt", 32'(reg_target), 32'h53);
    check("wr_data", 32'(data_out), 32'h1234);
    check("wr_status", 32'(status), 32'h11);

    // WRITE_REG held off while pipe 1 regfile is syncing
    regfile_syncing = 2'b10;
    cmdq = '{8'h21, 8'h07, 8'h0a, 8'hbe, 8'hef};
    send_cmd();
    repeat (10) @(posedge clk);
    #1;
    check("regwait_busy", 32'(state != 8'h00), 32'h1);
    push(KRw, 24'h2);
    regfile_syncing = 2'b00;
    @(negedge clk);
    wait_ready();
    check("sync_regtgt", 32'(reg_target), 32'h7a);
    check("sync_data", 32'(data_out), 32'hbeef);

    // WRITE_INSTR, ALLOC_DELAY, gains, pipeline reset
    push(KIw, 24'h1);
    cmdq = '{8'h10, 8'h01, 8'hde, 8'had, 8'hbe, 8'hef};
    send_cmd();
    wait_ready();
    check("instr", instr_out, 32'hdeadbeef);
    check("instr_status", 32'(status), 32'h01);
    push(KAd, 24'h2);
    cmdq = '{8'h41, 8'hab, 8'hcd, 8'h01, 8'h02, 8'h03, 8'h04};
    send_cmd();
    wait_ready();
    check("alloc_data", 32'(data_out), 32'habcd);
    check("alloc_delay", delay_out, 32'h01020304);
    push(KIg, 24'h1);
    cmdq = '{8'h70, 8'h55, 8'h66};
    send_cmd();
    wait_ready();
    check("ingain_data", 32'(data_out), 32'h5566);
    push(KOg, 24'h1);
    cmdq = '{8'h80, 8'h77, 8'h88};
    send_cmd();
    wait_ready();
    check("outgain_data", 32'(data_out), 32'h7788);
    push(KPr, 24'h2);
    cmdq = '{8'h61};
    send_cmd();
    wait_ready();
    check("rstpipe_status", 32'(status), 32'h11);

    // Invalid commands: unknown opcode, pipe out of range, swap to the active pipe
    push(KInv, 24'h1);
    send_byte(8'h93);
    wait_ready();
    check("inv_op_status", 32'(status), 32'h02);
    push(KInv, 24'h1);
    send_byte(8'h23);
    wait_ready();
    check("inv_pipe_status", 32'(status), 32'h32);
    push(KInv, 24'h1);
    send_byte(8'h50);
    wait_ready();
    check("inv_swap_status", 32'(status), 32'h02);

    // SWAP to pipe 1
    push(KRc, 24'h2);
    push(KSw, 24'h1);
    push(KFr, 24'h1);
    cmdq = '{8'h51};
    send_cmd();
    for (int i = 0; i < 20 && !swapping; i++) @(negedge clk);
    check("swap_enables_both", 32'(enables), 32'h3);
    check("swap_active_old", 32'(active_pipe), 32'h0);
    wait_ready();
    check("swap_enables", 32'(enables), 32'h2);
    check("swap_active", 32'(active_pipe), 32'h1);
    check("swap_status", 32'(status), 32'h11);

    // Timeout inside WRITE_INSTR, then a normal COMMIT
    push(KTmo, 24'h1);
    send_byte(8'h10);
    send_byte(8'h02);
    repeat (10) @(negedge clk);
    check("tmo_not_early", 32'(state != 8'h00), 32'h1);
    wait_ready();
    check("tmo_status", 32'(status), 32'h03);
    push(KRc, 24'h1);
    cmdq = '{8'h30};
    send_cmd();
    wait_ready();
    check("commit_status", 32'(status), 32'h01);

`ifdef CTRL_CHECKSUM_EN
    push(KRc, 24'h1);
    send_byte(8'h30);
    send_byte(8'h30);
    wait_ready();
    push(KInv, 24'h1);
    send_byte(8'h30);
    send_byte(8'h31);
    wait_ready();
    check("csum_status", 32'(status), 32'h04);
`endif

    // Reset mid-command, then reset while waiting in REG_WAIT
    send_byte(8'h21);
    send_byte(8'h05);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("midrst_state", 32'(state), 32'h0);
    check("midrst_enables", 32'(enables), 32'h1);
    check("midrst_active", 32'(active_pipe), 32'h0);
    check("midrst_status", 32'(status), 32'h0);
    regfile_syncing = 2'b10;
    cmdq = '{8'h21, 8'h09, 8'h01, 8'h44, 8'h55};
    send_cmd();
    repeat (3) @(negedge clk);
    check("regwait_before_rst", 32'(state != 8'h00), 32'h1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    regfile_syncing = 2'b00;
    repeat (5) @(negedge clk);
    check("rst_regwait_state", 32'(state), 32'h0);
    check("rst_regwait_data", 32'(data_out), 32'h0);

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 32'(sbq.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
